// File: rtl/data_channel_arbiter_if.sv
// Control-ring port bundle of the data channel arbiter: rx packet in, grant/owner status out.
// The arbiter uses the slave modport; the ring side (or a bench) uses master.
interface data_channel_arbiter_if #(
   parameter int NUM_NODES = 4
);
   logic [31:0]          control_rx_packet;
   logic [31:0]          control_tx_packet;
   logic [15:0]          owner_id;
   logic                 busy;
   logic [NUM_NODES-1:0] pending;
   logic                 timeout_pulse;

   modport master (
      output control_rx_packet,
      input  control_tx_packet, owner_id, busy, pending, timeout_pulse
   );

   modport slave (
      input  control_rx_packet,
      output control_tx_packet, owner_id, busy, pending, timeout_pulse
   );
endinterface

// File: rtl/data_channel_arbiter.sv
// Round-robin owner arbiter for the shared data channel; ARB_TIMEOUT_EN adds the hold watchdog.
// REQ-to-grant latency 2 cycles, outputs registered; no backpressure, one rx packet accepted per cycle.
module data_channel_arbiter #(
   parameter int NUM_NODES = 4,
   parameter int TIMEOUT   = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   data_channel_arbiter_if.slave bus
);
   typedef struct packed {
      logic [15:0] src_id;
      logic [15:0] cmd;
   } ctrl_pkt_t;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      HOLD
`ifdef ARB_TIMEOUT_EN
      , REVOKE
`endif
   } state_t;

   localparam logic [15:0] CMD_REQ   = 16'h0001;
   localparam logic [15:0] CMD_REL   = 16'h0002;
   localparam logic [15:0] TX_GRANT  = 16'hFFFF;

   if (NUM_NODES < 1 || TIMEOUT < 2) begin : g_bad_param
      $error("data_channel_arbiter: NUM_NODES must be >=1 and TIMEOUT >=2");
   end

   state_t               state;
   logic [15:0]          owner_q;
   logic [15:0]          last_winner;
   logic [NUM_NODES-1:0] pending_q;
   logic [31:0]          tx_q;
   logic                 busy_q;

   ctrl_pkt_t            rx;
   logic                 src_ok;
   logic                 from_owner;
   logic                 rx_req;
   logic                 rx_rel;
   logic [NUM_NODES-1:0] rx_set;
   logic [NUM_NODES-1:0] rx_clr;
   logic [NUM_NODES-1:0] win_mask;
   logic                 win_found;
   logic [15:0]          win_id;

   assign rx         = bus.control_rx_packet;
   assign src_ok     = (rx.src_id != 16'd0) && (rx.src_id <= 16'(NUM_NODES));
   // owner_q is 0 when free, so this can only match a real owner
   assign from_owner = src_ok && (rx.src_id == owner_q);
   assign rx_req     = src_ok && (rx.cmd == CMD_REQ);
   assign rx_rel     = src_ok && (rx.cmd == CMD_REL);

   always_comb begin
      rx_set = '0;
      rx_clr = '0;
      if (src_ok && !from_owner) begin
         if (rx_req) rx_set[int'(rx.src_id) - 1] = 1'b1;
         if (rx_rel) rx_clr[int'(rx.src_id) - 1] = 1'b1;
      end
   end

   // Search starts one past the last winner and wraps back to node 1.
   always_comb begin
      int cand;
      cand      = 0;
      win_found = 1'b0;
      win_id    = 16'd0;
      win_mask  = '0;
      for (int off = 1; off <= NUM_NODES; off++) begin
         cand = (int'(last_winner) + off - 1) % NUM_NODES;
         if (!win_found && pending_q[cand]) begin
            win_found      = 1'b1;
            win_id         = 16'(cand + 1);
            win_mask[cand] = 1'b1;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [15:0] TX_REVOKE = 16'hFFFE;
   logic [CNT_W-1:0] hold_cnt;
   logic             pulse_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         owner_q     <= 16'd0;
         last_winner <= 16'(NUM_NODES);
         pending_q   <= '0;
         tx_q        <= 32'd0;
         busy_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         hold_cnt    <= '0;
         pulse_q     <= 1'b0;
`endif
      end else begin
         tx_q <= 32'd0;
`ifdef ARB_TIMEOUT_EN
         pulse_q <= 1'b0;
`endif
         // Winner clear first, then this cycle's rx updates on top.
         pending_q <= ((pending_q & ~((state == IDLE) ? win_mask : '0)) | rx_set) & ~rx_clr;
         case (state)
            IDLE: begin
               if (win_found) begin
                  state       <= GRANT;
                  owner_q     <= win_id;
                  last_winner <= win_id;
                  tx_q        <= {win_id, TX_GRANT};
                  busy_q      <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                  hold_cnt    <= '0;
`endif
               end
            end
            GRANT, HOLD: begin
               if (from_owner && rx_rel) begin
                  state   <= IDLE;
                  owner_q <= 16'd0;
                  busy_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
               end else if (state == HOLD && hold_cnt == CNT_W'(TIMEOUT)) begin
                  state   <= REVOKE;
                  tx_q    <= {owner_q, TX_REVOKE};
                  pulse_q <= 1'b1;
`endif
               end else begin
                  state <= HOLD;
`ifdef ARB_TIMEOUT_EN
                  if (hold_cnt != CNT_W'(TIMEOUT)) hold_cnt <= hold_cnt + 1'b1;
`endif
               end
            end
            default: begin
               state   <= IDLE;
               owner_q <= 16'd0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.control_tx_packet = tx_q;
   assign bus.owner_id          = owner_q;
   assign bus.busy              = busy_q;
   assign bus.pending           = pending_q;
`ifdef ARB_TIMEOUT_EN
   assign bus.timeout_pulse     = pulse_q;
`else
   assign bus.timeout_pulse     = 1'b0;
`endif
endmodule

// File: tb/tb_data_channel_arbiter.sv
// Self-checking bench for data_channel_arbiter: directed scenarios plus a randomized run
// compared against an ownership-level reference model.
module tb_data_channel_arbiter;
   localparam int NUM_NODES = 4;
   localparam int TIMEOUT   = 8;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   data_channel_arbiter_if #(.NUM_NODES(NUM_NODES)) bus ();

   data_channel_arbiter #(.NUM_NODES(NUM_NODES), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: who owns the channel, how long since its grant, queued requesters.
   int   m_owner;
   int   m_age;
   bit   m_revoking;
   int   m_last;
   bit   m_pend [1:NUM_NODES];
   logic [31:0] m_tx;
   bit   m_pulse;

   function automatic logic [NUM_NODES-1:0] m_pend_vec();
      logic [NUM_NODES-1:0] v;
      v = '0;
      for (int i = 1; i <= NUM_NODES; i++) v[i-1] = m_pend[i];
      return v;
   endfunction

   task automatic model_update(input logic [31:0] pkt, input logic r);
      int src;
      int cmd;
      bit valid;
      bit owner_pkt;
      bit nxt [1:NUM_NODES];
      bit found;
      int id;
      src = int'(pkt[31:16]);
      cmd = int'(pkt[15:0]);
      m_tx = 32'd0;
      m_pulse = 1'b0;
      if (r) begin
         m_owner = 0; m_age = -1; m_revoking = 0; m_last = NUM_NODES;
         for (int i = 1; i <= NUM_NODES; i++) m_pend[i] = 0;
         return;
      end
      valid = (src >= 1) && (src <= NUM_NODES);
      owner_pkt = valid && (m_owner != 0) && (src == m_owner);
      nxt = m_pend;
      if (m_owner == 0) begin
         found = 0;
         for (int k = 1; k <= NUM_NODES; k++) begin
            id = (m_last + k - 1) % NUM_NODES + 1;
            if (!found && m_pend[id]) begin
               found = 1;
               nxt[id] = 0;
               m_owner = id; m_last = id; m_age = 0;
               m_tx = {16'(id), 16'hFFFF};
            end
         end
      end else if (m_revoking) begin
         m_owner = 0; m_age = -1; m_revoking = 0;
      end else if (owner_pkt && cmd == 2) begin
         m_owner = 0; m_age = -1;
`ifdef ARB_TIMEOUT_EN
      end else if (m_age == TIMEOUT) begin
         m_revoking = 1;
         m_tx = {16'(m_owner), 16'hFFFE};
         m_pulse = 1;
`endif
      end else begin
         m_age++;
      end
      if (valid && !owner_pkt) begin
         if (cmd == 1) nxt[src] = 1;
         if (cmd == 2) nxt[src] = 0;
      end
      m_pend = nxt;
   endtask

   task automatic step(input logic [31:0] pkt);
      bus.control_rx_packet = pkt;
      @(posedge clk);
      model_update(pkt, rst);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(32'd0);
      step(32'd0);
      rst = 1'b0;
      checks += 5;
      if (bus.control_tx_packet !== 32'd0) begin errors++; $display("FAIL reset_tx: got %h expected 0", bus.control_tx_packet); end
      if (bus.owner_id !== 16'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", bus.owner_id); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      if (bus.pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b expected 0000", bus.pending); end
      if (bus.timeout_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b expected 0", bus.timeout_pulse); end
   endtask

   task automatic test_basic_grant();
      step(32'h0001_0001);
      checks += 2;
      if (bus.pending !== 4'b0001) begin errors++; $display("FAIL req_pending: got %b expected 0001", bus.pending); end
      if (bus.control_tx_packet !== 32'd0) begin errors++; $display("FAIL req_early_tx: got %h expected 0", bus.control_tx_packet); end
      step(32'd0);
      checks += 4;
      if (bus.control_tx_packet !== 32'h0001_FFFF) begin errors++; $display("FAIL grant1_tx: got %h expected 0001ffff", bus.control_tx_packet); end
      if (bus.owner_id !== 16'd1) begin errors++; $display("FAIL grant1_owner: got %0d expected 1", bus.owner_id); end
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL grant1_busy: got %b expected 1", bus.busy); end
      if (bus.pending !== 4'b0000) begin errors++; $display("FAIL grant1_pending: got %b expected 0000", bus.pending); end
      step(32'd0);
      checks += 2;
      if (bus.control_tx_packet !== 32'd0) begin errors++; $display("FAIL grant1_one_cycle: got %h expected 0", bus.control_tx_packet); end
      if (bus.owner_id !== 16'd1) begin errors++; $display("FAIL hold1_owner: got %0d expected 1", bus.owner_id); end
   endtask

   task automatic test_round_robin();
      step(32'h0003_0001);
      step(32'h0002_0001);
      step(32'h0001_0001);
      checks += 1;
      if (bus.pending !== 4'b0110) begin errors++; $display("FAIL rr_pending: got %b expected 0110", bus.pending); end
      step(32'h0001_0002);
      checks += 2;
      if (bus.owner_id !== 16'd0) begin errors++; $display("FAIL rr_rel1_owner: got %0d expected 0", bus.owner_id); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL rr_rel1_busy: got %b expected 0", bus.busy); end
      step(32'd0);
      checks += 1;
      if (bus.control_tx_packet !== 32'h0002_FFFF) begin errors++; $display("FAIL rr_grant2: got %h expected 0002ffff", bus.control_tx_packet); end
      step(32'd0);
      step(32'h0002_0002);
      step(32'd0);
      checks += 2;
      if (bus.control_tx_packet !== 32'h0003_FFFF) begin errors++; $display("FAIL rr_grant3: got %h expected 0003ffff", bus.control_tx_packet); end
      if (bus.owner_id !== 16'd3) begin errors++; $display("FAIL rr_owner3: got %0d expected 3", bus.owner_id); end
      step(32'h0003_0002);
   endtask

   task automatic test_invalid_ids();
      int bad_tx;
      bad_tx = 0;
      step(32'h0005_0001);
      step(32'h0000_0001);
      step(32'h0002_0003);
      for (int i = 0; i < 3; i++) begin
         if (bus.control_tx_packet !== 32'd0) bad_tx++;
         step(32'd0);
      end
      checks += 3;
      if (bus.pending !== 4'b0000) begin errors++; $display("FAIL invalid_pending: got %b expected 0000", bus.pending); end
      if (bad_tx != 0) begin errors++; $display("FAIL invalid_grant: got %0d grant cycles expected 0", bad_tx); end
      if (bus.owner_id !== 16'd0) begin errors++; $display("FAIL invalid_owner: got %0d expected 0", bus.owner_id); end
   endtask

   task automatic test_cancel();
      step(32'h0001_0001);
      step(32'd0);
      step(32'h0002_0001);
      checks += 1;
      if (bus.pending !== 4'b0010) begin errors++; $display("FAIL cancel_set: got %b expected 0010", bus.pending); end
      step(32'h0002_0002);
      checks += 1;
      if (bus.pending !== 4'b0000) begin errors++; $display("FAIL cancel_clr: got %b expected 0000", bus.pending); end
      step(32'h0001_0002);
      step(32'd0);
      step(32'd0);
      checks += 3;
      if (bus.owner_id !== 16'd0) begin errors++; $display("FAIL cancel_owner: got %0d expected 0", bus.owner_id); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b expected 0", bus.busy); end
      if (bus.control_tx_packet !== 32'd0) begin errors++; $display("FAIL cancel_tx: got %h expected 0", bus.control_tx_packet); end
   endtask

   task automatic test_timeout();
      int early;
      early = 0;
      step(32'h0004_0001);
      step(32'd0);
      checks += 1;
      if (bus.control_tx_packet !== 32'h0004_FFFF) begin errors++; $display("FAIL to_grant4: got %h expected 0004ffff", bus.control_tx_packet); end
      for (int i = 1; i <= TIMEOUT; i++) begin
         step(32'd0);
         if (bus.control_tx_packet !== 32'd0 || bus.timeout_pulse !== 1'b0) early++;
      end
      checks += 1;
      if (early != 0) begin errors++; $display("FAIL to_early: got %0d active cycles expected 0", early); end
      step(32'd0);
`ifdef ARB_TIMEOUT_EN
      checks += 3;
      if (bus.control_tx_packet !== 32'h0004_FFFE) begin errors++; $display("FAIL to_revoke_tx: got %h expected 0004fffe", bus.control_tx_packet); end
      if (bus.timeout_pulse !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected 1", bus.timeout_pulse); end
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL to_revoke_busy: got %b expected 1", bus.busy); end
      step(32'h0004_0002);
      checks += 3;
      if (bus.owner_id !== 16'd0) begin errors++; $display("FAIL to_after_owner: got %0d expected 0", bus.owner_id); end
      if (bus.timeout_pulse !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b expected 0", bus.timeout_pulse); end
      if (bus.control_tx_packet !== 32'd0) begin errors++; $display("FAIL to_after_tx: got %h expected 0", bus.control_tx_packet); end
`else
      checks += 2;
      if (bus.control_tx_packet !== 32'd0 || bus.timeout_pulse !== 1'b0) begin errors++; $display("FAIL to_no_revoke: got tx %h pulse %b expected 0 0", bus.control_tx_packet, bus.timeout_pulse); end
      if (bus.owner_id !== 16'd4) begin errors++; $display("FAIL to_hold_owner: got %0d expected 4", bus.owner_id); end
      for (int i = 0; i < 20; i++) step(32'd0);
      checks += 1;
      if (bus.owner_id !== 16'd4) begin errors++; $display("FAIL to_hold_long: got %0d expected 4", bus.owner_id); end
      step(32'h0004_0002);
      checks += 1;
      if (bus.owner_id !== 16'd0) begin errors++; $display("FAIL to_release: got %0d expected 0", bus.owner_id); end
`endif
   endtask

   task automatic test_reset_mid_hold();
      step(32'h0001_0001);
      step(32'd0);
      step(32'd0);
      step(32'h0002_0001);
      step(32'h0003_0001);
      checks += 1;
      if (bus.pending !== 4'b0110) begin errors++; $display("FAIL rst_pre_pending: got %b expected 0110", bus.pending); end
      rst = 1'b1;
      step(32'd0);
      rst = 1'b0;
      checks += 5;
      if (bus.control_tx_packet !== 32'd0) begin errors++; $display("FAIL rst_hold_tx: got %h expected 0", bus.control_tx_packet); end
      if (bus.owner_id !== 16'd0) begin errors++; $display("FAIL rst_hold_owner: got %0d expected 0", bus.owner_id); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_hold_busy: got %b expected 0", bus.busy); end
      if (bus.pending !== 4'b0000) begin errors++; $display("FAIL rst_hold_pending: got %b expected 0000", bus.pending); end
      if (bus.timeout_pulse !== 1'b0) begin errors++; $display("FAIL rst_hold_pulse: got %b expected 0", bus.timeout_pulse); end
      step(32'h0003_0001);
      checks += 1;
      if (bus.control_tx_packet !== 32'd0) begin errors++; $display("FAIL rst_req_early: got %h expected 0", bus.control_tx_packet); end
      step(32'd0);
      checks += 2;
      if (bus.control_tx_packet !== 32'h0003_FFFF) begin errors++; $display("FAIL rst_grant3: got %h expected 0003ffff", bus.control_tx_packet); end
      if (bus.owner_id !== 16'd3) begin errors++; $display("FAIL rst_owner3: got %0d expected 3", bus.owner_id); end
      step(32'h0003_0002);
   endtask

   task automatic test_random();
      logic [15:0] cmds [5];
      logic [31:0] pkt;
      cmds[0] = 16'h0001; cmds[1] = 16'h0002; cmds[2] = 16'h0001;
      cmds[3] = 16'h0002; cmds[4] = 16'h0007;
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 2) == 0) pkt = 32'd0;
         else pkt = {16'($urandom_range(0, 5)), cmds[$urandom_range(0, 4)]};
         step(pkt);
         checks += 5;
         if (bus.control_tx_packet !== m_tx) begin errors++; $display("FAIL rnd_tx[%0d]: got %h expected %h", n, bus.control_tx_packet, m_tx); end
         if (bus.owner_id !== 16'(m_owner)) begin errors++; $display("FAIL rnd_owner[%0d]: got %0d expected %0d", n, bus.owner_id, m_owner); end
         if (bus.busy !== (m_owner != 0)) begin errors++; $display("FAIL rnd_busy[%0d]: got %b expected %b", n, bus.busy, m_owner != 0); end
         if (bus.pending !== m_pend_vec()) begin errors++; $display("FAIL rnd_pending[%0d]: got %b expected %b", n, bus.pending, m_pend_vec()); end
         if (bus.timeout_pulse !== m_pulse) begin errors++; $display("FAIL rnd_pulse[%0d]: got %b expected %b", n, bus.timeout_pulse, m_pulse); end
      end
      rst = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.control_rx_packet = 32'd0;
      test_reset();
      test_basic_grant();
      test_round_robin();
      test_invalid_ids();
      test_cancel();
      test_timeout();
      test_reset_mid_hold();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
